// File: rtl/full_adder_pkg.sv
// Shared constants and per-bit full-adder equations for the full_adder slice.
package full_adder_pkg;

    localparam int MIN_WIDTH = 1;
    localparam int MAX_WIDTH = 64;

    function automatic logic fa_sum(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    // Generate when both operands are set, propagate an incoming carry when exactly one is.
    function automatic logic fa_carry(input logic a, input logic b, input logic c);
        return (a & b) | (c & (a ^ b));
    endfunction

endpackage

// File: rtl/full_adder_bit_cell.sv
// Purely combinational one-bit full adder, the ripple-chain building block.
module fa_bit_cell
    import full_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = fa_sum(a, b, ci);
    assign co = fa_carry(a, b, ci);

endmodule

// File: rtl/full_adder.sv
// Width-parameterised ripple-carry full adder with an optional output register stage.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             out_valid
);

    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("full_adder: WIDTH must be in 1..64");
    end

    logic [WIDTH:0]   chain;
    logic [WIDTH-1:0] sum_comb;

    assign chain[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        fa_bit_cell u_cell (
            .a  (a[i]),
            .b  (b[i]),
            .ci (chain[i]),
            .s  (sum_comb[i]),
            .co (chain[i+1])
        );
    end

    if (REG_OUT) begin : g_reg
        logic [WIDTH-1:0] sum_q;
        logic             carry_q;
        logic             valid_q;

        // Result registers load only on accepted inputs so unknown operands in idle cycles never reach them.
        always_ff @(posedge clk) begin
            if (rst) begin
                sum_q   <= '0;
                carry_q <= 1'b0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= in_valid;
                if (in_valid) begin
                    sum_q   <= sum_comb;
                    carry_q <= chain[WIDTH];
                end
            end
        end

        assign sum       = sum_q;
        assign carry     = carry_q;
        assign out_valid = valid_q;
    end else begin : g_comb
        assign sum       = sum_comb;
        assign carry     = chain[WIDTH];
        assign out_valid = in_valid & ~rst;
    end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: truth table, reset, hold, wide and combinational variants, random regression.
module tb_full_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // WIDTH=1 registered instance
    logic       v1 = 1'b0, a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
    logic       s1, k1, ov1;
    // WIDTH=4 registered instance
    logic       v4 = 1'b0, c4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0, s4;
    logic       k4, ov4;
    // WIDTH=1 combinational instance
    logic       v0 = 1'b0, a0 = 1'b0, b0 = 1'b0, c0 = 1'b0;
    logic       s0, k0, ov0;
    // WIDTH=8 registered instance
    logic       v8 = 1'b0, c8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, s8;
    logic       k8, ov8;

    logic [1:0] q1[$];
    logic [4:0] q4[$];
    logic [8:0] q8[$];

    full_adder #(.WIDTH(1), .REG_OUT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
        .sum(s1), .carry(k1), .out_valid(ov1));
    full_adder #(.WIDTH(4), .REG_OUT(1'b1)) dut4 (
        .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4), .cin(c4),
        .sum(s4), .carry(k4), .out_valid(ov4));
    full_adder #(.WIDTH(1), .REG_OUT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(v0), .a(a0), .b(b0), .cin(c0),
        .sum(s0), .carry(k0), .out_valid(ov0));
    full_adder #(.WIDTH(8), .REG_OUT(1'b1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .cin(c8),
        .sum(s8), .carry(k8), .out_valid(ov8));

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic test_reset();
        rst = 1'b1;
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        for (int n = 0; n < 2; n++) begin
            @(posedge clk); #1;
            checks++;
            if ({k1, s1, ov1} !== 3'b000) begin
                errors++;
                $display("[TB] FAIL reset_hold cycle %0d: carry/sum/valid=%b expected 000", n, {k1, s1, ov1});
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({k1, s1, ov1} !== 3'b111) begin
            errors++;
            $display("[TB] FAIL reset_release: carry/sum/valid=%b expected 111", {k1, s1, ov1});
        end
        v1 = 1'b0;
        q1.delete();
    endtask

    task automatic test_truth_table();
        logic [7:0] tt_sum;
        logic [7:0] tt_carry;
        logic [1:0] exp;
        tt_sum   = 8'b1001_0110;
        tt_carry = 8'b1110_1000;
        for (int i = 0; i <= 8; i++) begin
            @(posedge clk); #1;
            if (q1.size() > 0) begin
                exp = q1.pop_front();
                checks++;
                if (ov1 !== 1'b1 || {k1, s1} !== exp) begin
                    errors++;
                    $display("[TB] FAIL truth_table vec %0d: valid=%b carry,sum=%b expected valid=1 carry,sum=%b",
                             i - 1, ov1, {k1, s1}, exp);
                end
            end
            if (i < 8) begin
                v1 = 1'b1;
                {a1, b1, c1} = i[2:0];
                q1.push_back({tt_carry[i], tt_sum[i]});
            end else begin
                v1 = 1'b0;
            end
        end
    endtask

    task automatic test_hold();
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b0; c1 = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({k1, s1, ov1} !== 3'b101) begin
            errors++;
            $display("[TB] FAIL hold_load: carry/sum/valid=%b expected 101", {k1, s1, ov1});
        end
        v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({k1, s1, ov1} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL hold_idle: carry/sum/valid=%b expected 100", {k1, s1, ov1});
        end
        a1 = 1'bx; b1 = 1'bx; c1 = 1'bx;
        @(posedge clk); #1;
        checks++;
        if ({k1, s1, ov1} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL hold_x_inputs: carry/sum/valid=%b expected 100", {k1, s1, ov1});
        end
        a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    endtask

    task automatic test_back_to_back_w4();
        logic [4:0] exp;
        // Two vectors on consecutive cycles exercise full throughput.
        v4 = 1'b1; a4 = 4'hF; b4 = 4'h1; c4 = 1'b1;
        q4.push_back({1'b1, 4'h1});
        @(posedge clk); #1;
        v4 = 1'b1; a4 = 4'h5; b4 = 4'hA; c4 = 1'b0;
        q4.push_back({1'b0, 4'hF});
        exp = q4.pop_front();
        checks++;
        if (ov4 !== 1'b1 || {k4, s4} !== exp) begin
            errors++;
            $display("[TB] FAIL w4_F_plus_1: valid=%b carry,sum=%h expected valid=1 carry,sum=%h", ov4, {k4, s4}, exp);
        end
        @(posedge clk); #1;
        v4 = 1'b0;
        exp = q4.pop_front();
        checks++;
        if (ov4 !== 1'b1 || {k4, s4} !== exp) begin
            errors++;
            $display("[TB] FAIL w4_5_plus_A: valid=%b carry,sum=%h expected valid=1 carry,sum=%h", ov4, {k4, s4}, exp);
        end
    endtask

    task automatic test_comb();
        @(negedge clk);
        v0 = 1'b1; a0 = 1'b1; b0 = 1'b1; c0 = 1'b0;
        #1;
        checks++;
        if ({k0, s0, ov0} !== 3'b101) begin
            errors++;
            $display("[TB] FAIL comb_same_cycle: carry/sum/valid=%b expected 101", {k0, s0, ov0});
        end
        v0 = 1'b0; c0 = 1'b1;
        #1;
        checks++;
        if ({k0, s0, ov0} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL comb_invalid: carry/sum/valid=%b expected 110", {k0, s0, ov0});
        end
        v0 = 1'b1; rst = 1'b1;
        #1;
        checks++;
        if ({k0, s0, ov0} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL comb_in_reset: carry/sum/valid=%b expected 110", {k0, s0, ov0});
        end
        rst = 1'b0;
        #1;
        checks++;
        if (ov0 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL comb_reset_release: valid=%b expected 1", ov0);
        end
        v0 = 1'b0;
    endtask

    task automatic test_random_w8();
        logic [8:0] exp;
        int sent;
        int cycles;
        sent = 0;
        cycles = 0;
        q8.delete();
        while ((sent < 1000 || q8.size() > 0) && cycles < 3000) begin
            @(posedge clk); #1;
            cycles++;
            if (ov8 === 1'b1) begin
                checks++;
                if (q8.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL rand_w8 unexpected valid: carry,sum=%h expected no output", {k8, s8});
                end else begin
                    exp = q8.pop_front();
                    if ({k8, s8} !== exp) begin
                        errors++;
                        $display("[TB] FAIL rand_w8: carry,sum=%h expected %h", {k8, s8}, exp);
                    end
                end
            end else if (ov8 !== 1'b0) begin
                checks++;
                errors++;
                $display("[TB] FAIL rand_w8 valid unknown: valid=%b expected 0 or 1", ov8);
            end
            if (sent < 1000 && $urandom_range(0, 7) != 0) begin
                v8 = 1'b1;
                a8 = 8'($urandom);
                b8 = 8'($urandom);
                c8 = 1'($urandom);
                q8.push_back(9'(a8) + 9'(b8) + 9'(c8));
                sent++;
            end else begin
                v8 = 1'b0;
                a8 = 8'($urandom);
                b8 = 8'($urandom);
                c8 = 1'($urandom);
            end
        end
        v8 = 1'b0;
        checks++;
        if (sent != 1000 || q8.size() != 0) begin
            errors++;
            $display("[TB] FAIL rand_w8 drain: sent=%0d pending=%0d expected sent=1000 pending=0", sent, q8.size());
        end
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_hold();
        test_back_to_back_w4();
        test_comb();
        test_random_w8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
